// File: rtl/cpu_pkg.sv
// Shared fetch definitions: state encoding, instruction length constants and decode.
// INSTR_FETCH_HALT_EN turns opcode 8'hFF into a 1-byte HALT.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE  = 2'd0,
        ST_RECV   = 2'd1,
        ST_OUT    = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    localparam logic [7:0] OP_HALT = 8'hFF;

    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [1:0] len;
        case (op[7:6])
            2'b00:   len = LEN_1;
            2'b01:   len = LEN_2;
            default: len = LEN_3;
        endcase
`ifdef INSTR_FETCH_HALT_EN
        if (op == OP_HALT) len = LEN_1;
`endif
        return len;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: reads 1..3 bytes per instruction from external memory
// and presents them to the decoder. INSTR_FETCH_HALT_EN adds the HALT opcode and halted port.
module instr_fetch
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ip,
    output logic       ip_enable,
    output logic       ip_opsel,
    output logic [7:0] ip_load,
    output logic [7:0] imem_addr,
    output logic       imem_rd,
    input  logic [7:0] imem_data,
    input  logic       redirect,
    input  logic [7:0] redirect_tgt,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_op,
    output logic [7:0] instr_b1,
    output logic [7:0] instr_b2,
    output logic [1:0] instr_len,
    output logic [7:0] instr_ip
`ifdef INSTR_FETCH_HALT_EN
    ,
    output logic       halted
`endif
);

    fetch_state_e state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [7:0]   op_q, op_d;
    logic [7:0]   b1_q, b1_d;
    logic [7:0]   b2_q, b2_d;
    logic [7:0]   iip_q, iip_d;
    logic [1:0]   len_q, len_d;
    logic [1:0]   rcv_len;
    logic         rd_c, en_c, opsel_c, valid_c;

    // The opcode is still on imem_data while its own byte is received.
    assign rcv_len = (cnt_q == 2'd0) ? decode_len(imem_data) : len_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        iip_d   = iip_q;
        len_d   = len_q;
        rd_c    = 1'b0;
        en_c    = 1'b0;
        opsel_c = 1'b0;
        valid_c = 1'b0;

        if (redirect) begin
            en_c    = 1'b1;
            opsel_c = 1'b1;
            state_d = ST_ISSUE;
            cnt_d   = 2'd0;
            op_d    = 8'h00;
            b1_d    = 8'h00;
            b2_d    = 8'h00;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    rd_c    = 1'b1;
                    en_c    = 1'b1;
                    if (cnt_q == 2'd0) iip_d = ip;
                    state_d = ST_RECV;
                end
                ST_RECV: begin
                    case (cnt_q)
                        2'd0: begin
                            op_d  = imem_data;
                            b1_d  = 8'h00;
                            b2_d  = 8'h00;
                            len_d = rcv_len;
                        end
                        2'd1:    b1_d = imem_data;
                        default: b2_d = imem_data;
                    endcase
                    if (2'(cnt_q + 2'd1) == rcv_len) begin
                        state_d = ST_OUT;
                    end else begin
                        cnt_d   = 2'(cnt_q + 2'd1);
                        state_d = ST_ISSUE;
                    end
                end
                ST_OUT: begin
                    valid_c = 1'b1;
                    if (instr_ready) begin
                        cnt_d   = 2'd0;
                        state_d = ST_ISSUE;
`ifdef INSTR_FETCH_HALT_EN
                        if (op_q == OP_HALT) state_d = ST_HALTED;
`endif
                    end
                end
`ifdef INSTR_FETCH_HALT_EN
                ST_HALTED: state_d = ST_HALTED;
`endif
                default: state_d = ST_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ISSUE;
            cnt_q   <= 2'd0;
            op_q    <= 8'h00;
            b1_q    <= 8'h00;
            b2_q    <= 8'h00;
            iip_q   <= 8'h00;
            len_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            iip_q   <= iip_d;
            len_q   <= len_d;
        end
    end

    // Control outputs are forced low for the whole reset window, not just after the first edge.
    assign imem_rd     = rd_c & ~rst;
    assign ip_enable   = en_c & ~rst;
    assign ip_opsel    = opsel_c & ~rst;
    assign instr_valid = valid_c & ~rst;
    assign imem_addr   = ip;
    assign ip_load     = redirect_tgt;
    assign instr_op    = op_q;
    assign instr_b1    = b1_q;
    assign instr_b2    = b2_q;
    assign instr_len   = len_q;
    assign instr_ip    = iip_q;
`ifdef INSTR_FETCH_HALT_EN
    assign halted      = (state_q == ST_HALTED) & ~rst;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have ports (clock and reset first): clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have ip in 8: current instruction pointer from the IP register.
REQ-003 SHALL drive IP register controls:
- ip_enable out 1: update the IP register.
- ip_opsel out 1: 0 = increment, 1 = load.
- ip_load out 8: load value.
REQ-004 SHALL have the memory port:
- imem_addr out 8: read address.
- imem_rd out 1: read request.
- imem_data in 8: read data, valid exactly one cycle after imem_rd.
REQ-005 SHALL have redirect in 1 (branch taken) and redirect_tgt in 8 (branch target).
REQ-006 SHALL drive the decoder port:
- instr_valid out 1 and instr_ready in 1.
- instr_op, instr_b1, instr_b2 out 8 each: opcode, byte 1, byte 2.
- instr_len out 2: byte count, 1..3.
- instr_ip out 8: address of the opcode byte.

Function
REQ-007 SHALL decode instruction length from opcode[7:6]: 00 gives 1 byte, 01 gives 2 bytes, 1x gives 3 bytes.
REQ-008 SHALL implement states ISSUE, RECV and OUT, with byte counter cnt (0..2).
REQ-009 ISSUE SHALL assert imem_rd=1, imem_addr=ip, ip_enable=1, ip_opsel=0, then go to RECV; when cnt=0 it SHALL also latch ip into instr_ip.
REQ-010 RECV SHALL write imem_data into byte slot cnt, then:
- if cnt+1 = decoded length, go to OUT;
- otherwise increment cnt and go to ISSUE.
REQ-011 OUT SHALL assert instr_valid; when instr_ready=1, transfer occurs, cnt clears, and next state is ISSUE; otherwise hold with all instr_* outputs stable.
REQ-012 Latency from entering ISSUE to instr_valid SHALL be 2 cycles for 1-byte, 4 for 2-byte, 6 for 3-byte instructions.
REQ-013 Unused byte slots SHALL read 8'h00.
REQ-014 Outside ISSUE, with no redirect, ip_enable and imem_rd SHALL be 0.
REQ-015 Redirect handling: redirect=1 in any state SHALL, that cycle:
- assert ip_enable=1, ip_opsel=1, ip_load=redirect_tgt;
- force imem_rd=0 and instr_valid=0;
- discard partial bytes, clear cnt, and go to ISSUE.
REQ-016 Redirect SHALL win over a simultaneous instr_ready in OUT: no transfer occurs.
REQ-017 The IP SHALL wrap 8'hFF to 8'h00 (IP register behaviour); fetch SHALL continue across the wrap without special handling.
REQ-018 ip_load SHALL equal redirect_tgt at all times; it is only meaningful when ip_opsel=1.

Reset
REQ-019 While rst=1: imem_rd, ip_enable, ip_opsel and instr_valid SHALL be 0; state SHALL be ISSUE; cnt and all byte slots, instr_ip and instr_len SHALL be 0.
REQ-020 Reset asserted mid-instruction SHALL discard all partial state; the first ISSUE occurs in the cycle after rst deasserts.

Configuration
REQ-021 Macro INSTR_FETCH_HALT_EN: when defined:
- opcode 8'hFF is HALT, length 1;
- after HALT transfers, the block SHALL enter state HALTED, with no reads and ip_enable=0;
- only redirect or rst exits HALTED;
- an extra port halted out 1 is high in HALTED.
REQ-022 Without INSTR_FETCH_HALT_EN: there is no halted port and no HALTED state, and 8'hFF SHALL be an ordinary 3-byte opcode.

Structure
REQ-023 Shared package cpu_pkg SHALL hold: the fetch state enum, the length-decode function, the length constants, and the HALT opcode constant 8'hFF.
REQ-024 No sub-module SHALL be used; the memory is external to this block.

Verification
REQ-025 Reset, then memory[0]=8'h12 -> after 2 cycles instr_valid=1, instr_op=8'h12, instr_len=1, instr_ip=0, and the IP has incremented once.
REQ-026 memory[0..2]=8'h85,8'hAA,8'h55, instr_ready held 0 for 5 cycles -> instr_valid rises after 6 cycles, then instr_op=8'h85, instr_b1=8'hAA, instr_b2=8'h55, instr_len=3 all stay stable; with instr_ready=1 the next ISSUE uses imem_addr=3.
REQ-027 redirect=1, redirect_tgt=8'h40 during RECV of byte 1 of a 2-byte instruction -> ip_opsel=1, ip_load=8'h40, no instr_valid; the next ISSUE uses imem_addr=8'h40 with instr_ip=8'h40.
REQ-028 redirect=1 and instr_ready=1 in the same OUT cycle -> instr_valid=0 that cycle, no transfer, and fetch resumes at the target.
REQ-029 3-byte instruction at 8'hFE -> bytes are read from 8'hFE, 8'hFF, 8'h00, and instr_ip=8'hFE.
REQ-030 With INSTR_FETCH_HALT_EN, 8'hFF fetched and transferred -> halted=1 and imem_rd stays 0 for 10 cycles; redirect to 8'h10 -> halted=0 and a read at 8'h10.
